chunk_serial_addsub: RTL

Multi-cycle add/subtract unit that processes WIDTH-bit operands two bits per clock through a single internal 2-bit ripple-carry slice, propagating carry between slices in a register. It sits directly upstream of the 2-bit RCA datapath and sequences it: it accepts an operand pair, issues WIDTH/2 slice operations, and presents the assembled result. Trades latency for area in the adder/subtractor family.

---
 rtl/chunk_serial_addsub.sv | 137 +++++++++++++
 1 files changed

// File: rtl/chunk_serial_addsub.sv
// Multi-cycle adder/subtractor: two result bits per clock through one 2-bit ripple slice.
// Optional build macro ADDSUB_SATURATE_EN clamps overflowed results to the signed limit.
module chunk_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / 2;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [1:0]       a_sl_d;
    logic [1:0]       b_sl_d;
    logic [2:0]       slice_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_fin_d;
    logic             ovf_d;
    logic [IDXW:0]    base_d;

    // One 2-bit ripple slice; base_d is the bit offset of the current chunk.
    always_comb begin
        base_d  = {idx_q, 1'b0};
        a_sl_d  = a_q[base_d +: 2];
        b_sl_d  = bx_q[base_d +: 2];
        slice_d = {1'b0, a_sl_d} + {1'b0, b_sl_d} + {2'b00, carry_q};
        sum_d   = sum_q;
        sum_d[base_d +: 2] = slice_d[1:0];
        ovf_d     = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        sum_fin_d = sum_d;
`ifdef ADDSUB_SATURATE_EN
        if (ovf_d) begin
            sum_fin_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            bx_q        <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
                        a_q        <= A;
                        bx_q       <= Sub ? ~B : B;
                        carry_q    <= Sub;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry_q <= slice_d[2];
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q       <= sum_fin_d;
                        cout_q      <= slice_d[2];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        sum_q <= sum_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

    // Handshake invariants: accept only in IDLE, hold results under backpressure.
    a_excl : assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
    a_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(Sum) && $stable(Cout) && $stable(Ovf)));
    a_state : assert property (@(posedge clk) disable iff (rst) state_q != 2'd3);

endmodule
